// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package seg_pkg;

    // Canonical active-low hex font, bit order {g,f,e,d,c,b,a}; index = nibble value.
    localparam logic [6:0] FONT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000100, 7'b0001110
    };

    // All segments dark in active-low form.
    localparam logic [6:0] SEG_OFF_AL = 7'h7F;

    // Convert an active-low pattern to the pin polarity in use.
    function automatic logic [6:0] seg_polarity(input logic [6:0] pattern, input logic active_low);
        return active_low ? pattern : ~pattern;
    endfunction

    // Width of a digit index; a single-digit bank still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bus between the IO register (master) and the scan driver (slave).
interface seg_scan_if #(
    parameter int NUM_DIGITS = 8
);
    import seg_pkg::*;

    localparam int IDX_W = idx_w(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    load;
    logic                    enable;
    logic [NUM_DIGITS-1:0]   an_out;
    logic [6:0]              seg_out;
    logic                    dp_out;
    logic [IDX_W-1:0]        digit_idx;

    modport master (
        output data, dp_in, blank_in, load, enable,
        input  an_out, seg_out, dp_out, digit_idx
    );

    modport slave (
        input  data, dp_in, blank_in, load, enable,
        output an_out, seg_out, dp_out, digit_idx
    );

endinterface

// File: rtl/seg_scan_driver_hex7_font.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7_font
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] pattern_o
);

    assign pattern_o = FONT[nibble_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: shadow latch, refresh divider,
// digit scan with anti-ghost guard, font decode, blanking and
// leading-zero suppression. All pin outputs are registered.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 50000,
    parameter int ACTIVE_LOW   = 1,
    parameter int LZ_SUPPRESS  = 1,
    parameter int GUARD_CYCLES = 2
) (
    input logic       clk,
    input logic       reset,
    seg_scan_if.slave bus
);

    localparam int   IDX_W = idx_w(NUM_DIGITS);
    localparam int   CNT_W = $clog2(CLK_DIV);
    localparam logic AL    = (ACTIVE_LOW != 0);
    localparam logic LZ_EN = (LZ_SUPPRESS != 0);

    // Inactive pin levels for the configured polarity.
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AL}};
    localparam logic [6:0]            SEG_OFF = seg_polarity(SEG_OFF_AL, AL);
    localparam logic                  DP_OFF  = AL;

    // Scan position.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Shadow copy of the display request; the scan reads only this.
    logic [NUM_DIGITS-1:0][3:0] data_q;
    logic [NUM_DIGITS-1:0]      dp_q;
    logic [NUM_DIGITS-1:0]      blank_q;

    // Registered pin outputs.
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dpo_q, dpo_d;
    logic [IDX_W-1:0]      didx_q;

    // Per-digit decode helpers.
    logic [NUM_DIGITS-1:0] lz_dark;
    logic                  lz_run;
    logic [3:0]            cur_nib;
    logic [6:0]            font_pat;
    logic                  cur_dark;
    logic [NUM_DIGITS-1:0] an_sel;

    // Advance the divider while enabled; digit index steps on divider wrap.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (bus.enable) begin
            if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and every more significant digit
    // hold zero with no decimal point; digit 0 always stays lit.
    always_comb begin
        lz_run  = 1'b1;
        lz_dark = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run     = lz_run & (data_q[i] == 4'h0) & ~dp_q[i];
            lz_dark[i] = lz_run & LZ_EN;
        end
    end

    assign cur_nib  = data_q[idx_q];
    assign cur_dark = blank_q[idx_q] | lz_dark[idx_q];
    assign an_sel   = NUM_DIGITS'(1) << idx_q;

    hex7_font u_font (
        .nibble_i  (cur_nib),
        .pattern_o (font_pat)
    );

    // Next pin levels: anode held off during the guard window, segments
    // already carry the new digit so they settle before the anode lights.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dpo_d = DP_OFF;
        if (bus.enable) begin
            if (int'(cnt_q) >= GUARD_CYCLES) an_d = AL ? ~an_sel : an_sel;
            if (!cur_dark) seg_d = seg_polarity(font_pat, AL);
            if (!blank_q[idx_q] && dp_q[idx_q]) dpo_d = ~DP_OFF;
        end
    end

    // Scan state and shadow capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            dp_q    <= '0;
            blank_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            if (bus.load) begin
                data_q  <= bus.data;
                dp_q    <= bus.dp_in;
                blank_q <= bus.blank_in;
            end
        end
    end

    // Output registers; digit_idx lags the index so it matches the lit anode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q   <= AN_OFF;
            seg_q  <= SEG_OFF;
            dpo_q  <= DP_OFF;
            didx_q <= '0;
        end else begin
            an_q   <= an_d;
            seg_q  <= seg_d;
            dpo_q  <= dpo_d;
            didx_q <= idx_q;
        end
    end

    assign bus.an_out    = an_q;
    assign bus.seg_out   = seg_q;
    assign bus.dp_out    = dpo_q;
    assign bus.digit_idx = didx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: three configurations share one stimulus stream
// and are compared each cycle against a time-indexed display model.
module tb_seg_scan_driver;

    localparam int N  = 8;
    localparam int CD = 4;
    localparam int GD = 1;

    localparam logic [6:0] FONT_REF [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000100, 7'b0001110
    };

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] data = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  blank_in = '0;
    logic        load = 1'b0;
    logic        enable = 1'b0;

    int checks = 0;
    int failures = 0;

    seg_scan_if #(.NUM_DIGITS(N)) ifa ();
    seg_scan_if #(.NUM_DIGITS(N)) ifb ();
    seg_scan_if #(.NUM_DIGITS(N)) ifc ();

    assign ifa.data = data;  assign ifa.dp_in = dp_in;  assign ifa.blank_in = blank_in;
    assign ifa.load = load;  assign ifa.enable = enable;
    assign ifb.data = data;  assign ifb.dp_in = dp_in;  assign ifb.blank_in = blank_in;
    assign ifb.load = load;  assign ifb.enable = enable;
    assign ifc.data = data;  assign ifc.dp_in = dp_in;  assign ifc.blank_in = blank_in;
    assign ifc.load = load;  assign ifc.enable = enable;

    // A: active-low, no suppression. B: active-low, suppression. C: active-high, suppression.
    seg_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .ACTIVE_LOW(1), .LZ_SUPPRESS(0), .GUARD_CYCLES(GD))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));
    seg_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .ACTIVE_LOW(1), .LZ_SUPPRESS(1), .GUARD_CYCLES(GD))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));
    seg_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .ACTIVE_LOW(0), .LZ_SUPPRESS(1), .GUARD_CYCLES(GD))
        dut_c (.clk(clk), .reset(reset), .bus(ifc));

    wire [18:0] got_a = {ifa.an_out, ifa.seg_out, ifa.dp_out, ifa.digit_idx};
    wire [18:0] got_b = {ifb.an_out, ifb.seg_out, ifb.dp_out, ifb.digit_idx};
    wire [18:0] got_c = {ifc.an_out, ifc.seg_out, ifc.dp_out, ifc.digit_idx};

    // Model state: t counts enabled clock edges modulo one full scan.
    int          m_t;
    logic [31:0] m_data;
    logic [7:0]  m_dp, m_bl;
    logic [18:0] exp_a, exp_b, exp_c;

    // Expected pins {an, seg, dp, idx} for scan time t, from the display rules.
    function automatic logic [18:0] ref_out(bit al, bit lz, int t, bit en,
                                            logic [31:0] d, logic [7:0] dpv, logic [7:0] bl);
        int pos = t % CD;
        int dig = t / CD;
        bit upper_zero = 1'b1;
        bit dark;
        bit dp_on;
        logic [6:0] seg;
        logic [7:0] an;
        logic [3:0] nib;
        for (int j = dig; j < N; j++)
            if (((d >> (4 * j)) & 32'hF) != 0 || dpv[j]) upper_zero = 1'b0;
        dark  = bl[dig] || (lz && dig > 0 && upper_zero);
        nib   = 4'((d >> (4 * dig)) & 32'hF);
        seg   = dark ? 7'h7F : FONT_REF[nib];
        an    = (pos < GD) ? 8'hFF : ~(8'h01 << dig);
        dp_on = !bl[dig] && dpv[dig];
        if (!en) begin
            seg = 7'h7F; an = 8'hFF; dp_on = 1'b0;
        end
        if (al) return {an, seg, ~dp_on, 3'(dig)};
        return {~an, ~seg, dp_on, 3'(dig)};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_t <= 0; m_data <= '0; m_dp <= '0; m_bl <= '0;
            exp_a <= {8'hFF, 7'h7F, 1'b1, 3'd0};
            exp_b <= {8'hFF, 7'h7F, 1'b1, 3'd0};
            exp_c <= '0;
        end else begin
            exp_a <= ref_out(1'b1, 1'b0, m_t, enable, m_data, m_dp, m_bl);
            exp_b <= ref_out(1'b1, 1'b1, m_t, enable, m_data, m_dp, m_bl);
            exp_c <= ref_out(1'b0, 1'b1, m_t, enable, m_data, m_dp, m_bl);
            if (enable) m_t <= (m_t + 1) % (N * CD);
            if (load) begin
                m_data <= data; m_dp <= dp_in; m_bl <= blank_in;
            end
        end
    end

    task automatic load_value(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
        data = d; dp_in = dp; blank_in = bl; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (got_a !== {8'hFF, 7'h7F, 1'b1, 3'd0}) begin
            failures++; $display("FAIL reset_init_a got=%h exp=%h", got_a, {8'hFF, 7'h7F, 1'b1, 3'd0});
        end
        checks++;
        if (got_c !== 19'd0) begin
            failures++; $display("FAIL reset_init_c got=%h exp=%h", got_c, 19'd0);
        end
        reset = 1'b0; enable = 1'b1;
        for (int c = 0; c < 5 * CD + 2; c++) begin
            @(negedge clk);
            checks++;
            if (got_a !== exp_a) begin
                failures++; $display("FAIL reset_run_a cyc=%0d got=%h exp=%h", c, got_a, exp_a);
            end
        end
        checks++;
        if (ifa.digit_idx !== 3'd5) begin
            failures++; $display("FAIL reset_pre_idx got=%0d exp=5", ifa.digit_idx);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (got_a !== {8'hFF, 7'h7F, 1'b1, 3'd0}) begin
            failures++; $display("FAIL reset_async_a got=%h exp=%h", got_a, {8'hFF, 7'h7F, 1'b1, 3'd0});
        end
        checks++;
        if (got_b !== {8'hFF, 7'h7F, 1'b1, 3'd0}) begin
            failures++; $display("FAIL reset_async_b got=%h exp=%h", got_b, {8'hFF, 7'h7F, 1'b1, 3'd0});
        end
        checks++;
        if (got_c !== 19'd0) begin
            failures++; $display("FAIL reset_async_c got=%h exp=%h", got_c, 19'd0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_full_scan;
        int guard_cnt = 0;
        logic [2:0] prev_idx;
        load_value(32'h89ABCDEF, 8'h00, 8'h00);
        prev_idx = ifa.digit_idx;
        for (int c = 0; c < N * CD; c++) begin
            @(negedge clk);
            checks++;
            if (got_a !== exp_a) begin
                failures++; $display("FAIL scan_a cyc=%0d got=%h exp=%h", c, got_a, exp_a);
            end
            if (ifa.an_out === 8'hFF) guard_cnt++;
            if (ifa.an_out !== 8'hFF && ifa.digit_idx === 3'd0) begin
                checks++;
                if (ifa.seg_out !== 7'b0001110) begin
                    failures++; $display("FAIL scan_digit0 got=%b exp=0001110", ifa.seg_out);
                end
            end
            if (ifa.an_out !== 8'hFF && ifa.digit_idx === 3'd7) begin
                checks++;
                if (ifa.seg_out !== 7'b0000000) begin
                    failures++; $display("FAIL scan_digit7 got=%b exp=0000000", ifa.seg_out);
                end
            end
            if (prev_idx === 3'd7 && ifa.digit_idx !== 3'd7) begin
                checks++;
                if (ifa.digit_idx !== 3'd0) begin
                    failures++; $display("FAIL scan_wrap got=%0d exp=0", ifa.digit_idx);
                end
            end
            prev_idx = ifa.digit_idx;
        end
        checks++;
        if (guard_cnt != N) begin
            failures++; $display("FAIL scan_guard_cycles got=%0d exp=%0d", guard_cnt, N);
        end
    endtask

    task automatic test_leading_zero;
        load_value(32'h00000120, 8'h00, 8'h00);
        for (int c = 0; c < N * CD; c++) begin
            @(negedge clk);
            checks++;
            if (got_b !== exp_b) begin
                failures++; $display("FAIL lz_b cyc=%0d got=%h exp=%h", c, got_b, exp_b);
            end
            checks++;
            if (got_a !== exp_a) begin
                failures++; $display("FAIL lz_a cyc=%0d got=%h exp=%h", c, got_a, exp_a);
            end
            if (ifb.digit_idx >= 3'd3) begin
                checks++;
                if (ifb.seg_out !== 7'h7F) begin
                    failures++; $display("FAIL lz_dark idx=%0d got=%b exp=1111111", ifb.digit_idx, ifb.seg_out);
                end
            end
            if (ifb.digit_idx == 3'd2) begin
                checks++;
                if (ifb.seg_out !== 7'b1111001) begin
                    failures++; $display("FAIL lz_digit2 got=%b exp=1111001", ifb.seg_out);
                end
            end
        end
        load_value(32'h0, 8'h00, 8'h00);
        for (int c = 0; c < N * CD; c++) begin
            @(negedge clk);
            checks++;
            if (ifb.seg_out !== ((ifb.digit_idx == 3'd0) ? 7'b1000000 : 7'h7F)) begin
                failures++; $display("FAIL lz_zero idx=%0d got=%b", ifb.digit_idx, ifb.seg_out);
            end
        end
        load_value(32'h00000120, 8'h10, 8'h00);
        for (int c = 0; c < N * CD; c++) begin
            @(negedge clk);
            checks++;
            if (got_b !== exp_b) begin
                failures++; $display("FAIL lz_dp_b cyc=%0d got=%h exp=%h", c, got_b, exp_b);
            end
            checks++;
            if (got_c !== exp_c) begin
                failures++; $display("FAIL lz_dp_c cyc=%0d got=%h exp=%h", c, got_c, exp_c);
            end
            if (ifb.digit_idx == 3'd3) begin
                checks++;
                if (ifb.seg_out !== 7'b1000000) begin
                    failures++; $display("FAIL lz_dp_digit3 got=%b exp=1000000", ifb.seg_out);
                end
            end
        end
    endtask

    task automatic test_mid_load;
        int budget = 0;
        load_value(32'h11111111, 8'h00, 8'h00);
        while (!(ifa.digit_idx == 3'd3 && ifa.an_out === 8'hFF) && budget < 4 * N * CD) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (budget >= 4 * N * CD) begin
            failures++; $display("FAIL midload_wait got=timeout exp=digit3");
        end
        data = 32'h22222222; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (ifa.seg_out !== 7'b1111001) begin
            failures++; $display("FAIL midload_before got=%b exp=1111001", ifa.seg_out);
        end
        @(negedge clk);
        checks++;
        if (ifa.seg_out !== 7'b0100100 || ifa.an_out === 8'hFF || ifa.digit_idx !== 3'd3) begin
            failures++; $display("FAIL midload_switch seg=%b an=%h idx=%0d exp seg=0100100 an=active idx=3",
                                 ifa.seg_out, ifa.an_out, ifa.digit_idx);
        end
        for (int c = 0; c < N * CD; c++) begin
            @(negedge clk);
            checks++;
            if (got_a !== exp_a) begin
                failures++; $display("FAIL midload_a cyc=%0d got=%h exp=%h", c, got_a, exp_a);
            end
            checks++;
            if (ifa.seg_out !== 7'b0100100) begin
                failures++; $display("FAIL midload_mix cyc=%0d got=%b exp=0100100", c, ifa.seg_out);
            end
        end
    endtask

    task automatic test_enable_blank;
        logic [2:0] held;
        load_value(32'h76543210, 8'h00, 8'h00);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        held = ifa.digit_idx;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (got_a !== {8'hFF, 7'h7F, 1'b1, held}) begin
                failures++; $display("FAIL disable_a cyc=%0d got=%h exp=%h", c, got_a, {8'hFF, 7'h7F, 1'b1, held});
            end
            checks++;
            if (got_c !== exp_c) begin
                failures++; $display("FAIL disable_c cyc=%0d got=%h exp=%h", c, got_c, exp_c);
            end
        end
        enable = 1'b1;
        for (int c = 0; c < 2 * CD; c++) begin
            @(negedge clk);
            checks++;
            if (got_a !== exp_a) begin
                failures++; $display("FAIL resume_a cyc=%0d got=%h exp=%h", c, got_a, exp_a);
            end
        end
        load_value(32'h76543210, 8'h04, 8'h04);
        for (int c = 0; c < N * CD; c++) begin
            @(negedge clk);
            checks++;
            if (got_b !== exp_b) begin
                failures++; $display("FAIL blank_b cyc=%0d got=%h exp=%h", c, got_b, exp_b);
            end
            if (ifa.digit_idx == 3'd2) begin
                checks++;
                if (ifa.seg_out !== 7'h7F || ifa.dp_out !== 1'b1) begin
                    failures++; $display("FAIL blank_digit2 seg=%b dp=%b exp seg=1111111 dp=1", ifa.seg_out, ifa.dp_out);
                end
            end
        end
    endtask

    task automatic test_polarity;
        load_value(32'h11111111, 8'h00, 8'h00);
        for (int c = 0; c < N * CD; c++) begin
            @(negedge clk);
            checks++;
            if (got_c !== exp_c) begin
                failures++; $display("FAIL pol_c cyc=%0d got=%h exp=%h", c, got_c, exp_c);
            end
            if (ifc.an_out !== 8'h00) begin
                checks++;
                if (ifc.seg_out !== 7'b0000110 || ifc.an_out !== (8'h01 << ifc.digit_idx)) begin
                    failures++; $display("FAIL pol_active seg=%b an=%b exp seg=0000110 one-hot high", ifc.seg_out, ifc.an_out);
                end
            end
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            checks++;
            if (got_a !== exp_a) begin
                failures++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", c, got_a, exp_a);
            end
            checks++;
            if (got_b !== exp_b) begin
                failures++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", c, got_b, exp_b);
            end
            checks++;
            if (got_c !== exp_c) begin
                failures++; $display("FAIL rand_c cyc=%0d got=%h exp=%h", c, got_c, exp_c);
            end
            load   = ($urandom_range(0, 7) == 0);
            enable = ($urandom_range(0, 15) != 0);
            data   = $urandom >> $urandom_range(0, 31);
            dp_in  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            blank_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        end
        load = 1'b0; enable = 1'b1;
    endtask

    initial begin
        test_reset;
        test_full_scan;
        test_leading_zero;
        test_mid_load;
        test_enable_blank;
        test_polarity;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Multiplexed N-digit seven-segment display driver for the board's common-anode display bank. It latches a packed hex word into a shadow register and scans one digit at a time at a programmable refresh rate. Per digit it decodes the hex font and applies decimal-point, per-digit blanking and optional leading-zero suppression. It sits between the CPU's debug/IO register and the board display pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..16)
CLK_DIV, 50000, clk cycles each digit is held (>= 4)
ACTIVE_LOW, 1, 1 = segment and anode pins active-low; 0 = active-high
LZ_SUPPRESS, 1, 1 = blank leading zero digits; 0 = always show all digits
GUARD_CYCLES, 2, anode-off cycles at each digit switch, for anti-ghosting (0..CLK_DIV-2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
data  in  4*NUM_DIGITS  packed hex nibbles; digit i = data[4i+3:4i], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit
blank_in  in  NUM_DIGITS  force digit i dark
load  in  1  latch data/dp_in/blank_in into shadow on this clk edge
enable  in  1  0 = all anodes inactive, scan counter frozen
an_out  out  NUM_DIGITS  digit anode select, one-hot active, polarity per ACTIVE_LOW
seg_out  out  7  segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
dp_out  out  1  decimal point segment, polarity per ACTIVE_LOW
digit_idx  out  $clog2(NUM_DIGITS) (min 1)  index of currently driven digit

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-high, named reset. All state is cleared on assertion, with no clk edge required.
- Reset values: shadow regs 0; div counter 0; digit_idx 0; an_out all inactive; seg_out and dp_out all off (inactive level).
- Shadow: on load=1 at a clk edge, data, dp_in and blank_in are captured. The display uses only the shadow, so a value never tears mid-scan. A load on the same edge as a digit switch takes effect for the new digit.
- Divider: counts 0..CLK_DIV-1 while enable=1. At CLK_DIV-1 it wraps to 0 and digit_idx advances. digit_idx wraps from NUM_DIGITS-1 to 0.
- enable=0: counter and digit_idx hold. an_out, seg_out and dp_out go inactive on the next edge. On re-enable, the scan resumes from the held state.
- Guard: while the counter is below GUARD_CYCLES, an_out is all inactive. seg_out already carries the new digit's pattern during the guard window.
- Font: hex 0-F, canonical active-low patterns {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000100, F=0001110
  - When ACTIVE_LOW=0, the pattern is inverted.
- Leading-zero suppression (LZ_SUPPRESS=1): digit i is dark if every shadow nibble at index >= i is 0, i > 0, and dp is clear for all indices >= i. Digit 0 is never suppressed, so an all-zero value shows a single "0".
- Dark digit: seg_out all off and dp_out off. The anode still scans normally, so brightness stays uniform.
- Priority: blank_in > leading-zero suppression > font. dp_out follows the shadow dp for the current digit unless blank_in is set.
- Latency: all outputs are registered, one cycle after the internal counter/index state. digit_idx matches the digit whose anode is active.

Decomposition:
- Package seg_pkg:
  - FONT constant array of 16 x 7-bit active-low patterns
  - SEG_OFF_AL = 7'h7F
  - function seg_polarity(pattern, active_low)
- Sub-module hex7_font: combinational 4-bit nibble to 7-bit pattern via seg_pkg FONT. The driver instantiates one hex7_font, fed by a mux on digit_idx.
- The counter, scan index, shadow and output registers live in seg_scan_driver.

Test Plan:
1. Reset mid-scan with digit_idx=5: assert reset between edges. Immediately an_out=8'hFF, seg_out=7'h7F, dp_out=1 and digit_idx=0, with no clk edge required.
2. Full scan, data=32'h89ABCDEF, CLK_DIV=4, GUARD=1, LZ off, dp_in=0:
   - per digit, 1 cycle with an_out=FF, then 3 cycles with one anode low
   - seg_out for digit0 = 0001110 (F) and for digit7 = 0000000 (8)
   - digit_idx wraps 7 -> 0 after 32 cycles
3. Leading zeros, data=32'h00000120, LZ on: digits 3..7 dark, digits 2/1/0 show 1111001/0100100/1000000. data=0 gives only digit0 lit with "0". Setting dp_in[4] makes digits 3..4 lit.
4. Mid-scan load: set load with a new value while digit 3 is active. Digit 3's seg_out changes on the next cycle with no guard insertion. Digits scanned afterwards show the new value and never a mixture of old and new nibbles.
5. Enable and blank: enable=0 for 10 cycles gives all outputs inactive and digit_idx/counter frozen. Re-enable resumes from the same count. blank_in[2]=1 with dp_in[2]=1 keeps digit 2 fully dark.
6. Polarity, ACTIVE_LOW=0: digit value 1 drives seg_out=0000110 and the active anode is driven high.
